// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: word type, PC update modes,
// the reset/fault instruction, the FSM state encoding and the registered
// instruction record handed to decode.
package instr_fetch_pkg;

  typedef logic [31:0] word;

  localparam logic PC_MODE_INCREMENT = 1'b0;
  localparam logic PC_MODE_JUMP      = 1'b1;

  localparam int  INSTRUCTION_SIZE_IN_BYTES = 4;
  localparam word NOP_INSTR                 = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_START,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } fetch_state_e;

  // Instruction record as presented to decode.
  typedef struct packed {
    word  instr;
    word  addr;
    logic fault;
  } fetch_rsp_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: the instruction-memory read channel plus the
// instruction handshake towards decode.
//   master : the fetch stage (drives mem request and instr outputs)
//   slave  : the environment (memory + decode)
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic mem_req_valid;
  logic mem_req_ready;
  word  mem_addr;
  logic mem_rsp_valid;
  word  mem_rsp_data;
  logic mem_rsp_err;

  logic instr_valid;
  logic instr_ready;
  word  instr;
  word  instr_pc;
  logic instr_fault;

  modport master (
    output mem_req_valid, mem_addr, instr_valid, instr, instr_pc, instr_fault,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err, instr_ready
  );

  modport slave (
    input  mem_req_valid, mem_addr, instr_valid, instr, instr_pc, instr_fault,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err, instr_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage sitting directly after the PC register.
// Issues one word read per PC, captures the response and hands it to
// decode over valid/ready. Drives the PC register's enable/mode: increment
// once per completed fetch, jump on a redirect from execute. One memory
// request in flight at most; responses belonging to a redirected fetch
// are discarded.
// Ports:
//   clk, res        clock / async active-low reset
//   pc              current PC
//   pc_enable       PC update strobe (combinational)
//   pc_mode         PC_MODE_INCREMENT / PC_MODE_JUMP (combinational)
//   redirect        single-cycle jump request from execute
//   bus (master)    memory read channel + decode handshake
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter bit CheckAlign = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  input  word               pc,
  output logic              pc_enable,
  output logic              pc_mode,
  input  logic              redirect,
  instr_fetch_if.master     bus
);

  fetch_state_e state_q, state_d;
  fetch_rsp_t   out_q, out_d;
  word          req_pc_q, req_pc_d;
  logic         inc, req_v, hold_v, misaligned;

  assign misaligned = CheckAlign && (pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= S_START;
      out_q    <= '{instr: NOP_INSTR, addr: '0, fault: 1'b0};
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    req_pc_d = req_pc_q;
    inc      = 1'b0;
    req_v    = 1'b0;
    hold_v   = 1'b0;
    unique case (state_q)
      S_START: state_d = S_REQ;
      S_REQ: begin
        if (misaligned) begin
          // Never reaches memory; a fault record takes the slot instead.
          if (!redirect) begin
            out_d   = '{instr: NOP_INSTR, addr: pc, fault: 1'b1};
            inc     = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          req_v = !redirect;
          if (req_v && bus.mem_req_ready) begin
            req_pc_d = pc;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (redirect) state_d = S_REQ;   // response belongs to the old path
          else begin
            out_d   = '{instr: bus.mem_rsp_data, addr: req_pc_q, fault: bus.mem_rsp_err};
            inc     = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          state_d = S_DRAIN;
        end
      end
      // Swallow the one stale response. A further redirect here changes
      // nothing: we still only owe memory that single response, so leaving
      // as soon as it shows up cannot deadlock.
      S_DRAIN: if (bus.mem_rsp_valid) state_d = S_REQ;
      S_HOLD: begin
        hold_v = !redirect;
        if (redirect || bus.instr_ready) state_d = S_REQ;
      end
      default: state_d = S_START;
    endcase
  end

  // Redirect wins over any increment in the same cycle. Strobes are
  // gated by reset so nothing leaks out while the block is held.
  assign pc_enable = res & (redirect | inc);
  assign pc_mode   = redirect ? PC_MODE_JUMP : PC_MODE_INCREMENT;

  assign bus.mem_req_valid = res & req_v;
  assign bus.mem_addr      = pc;
  assign bus.instr_valid   = res & hold_v;
  assign bus.instr         = out_q.instr;
  assign bus.instr_pc      = out_q.addr;
  assign bus.instr_fault   = out_q.fault;

  // Memory must never answer when no request is outstanding.
  a_rsp_legal: assert property (@(posedge clk) disable iff (!res)
    !(bus.mem_rsp_valid && (state_q == S_REQ || state_q == S_HOLD)));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic redirect = 1'b0;
  logic pc_enable, pc_mode;
  logic mready = 1'b1;
  logic rdy = 1'b1;
  word  pc;
  word  target = '0;
  word  err_addr = 32'hFFFF_FFFF;
  int   lat = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic       rsp_v;
  int         cnt;
  word        paddr;
  fetch_rsp_t sb[$];

  instr_fetch_if bus();

  instr_fetch #(.CheckAlign(1'b1)) dut (
    .clk       (clk),
    .res       (res),
    .pc        (pc),
    .pc_enable (pc_enable),
    .pc_mode   (pc_mode),
    .redirect  (redirect),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic word data_of(input word a);
    return {a[15:0], 16'hC0DE} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string tag, input word obs, input word exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // PC register model
  always @(posedge clk or negedge res) begin
    if (!res) pc <= '0;
    else if (pc_enable) pc <= (pc_mode == PC_MODE_JUMP) ? target : pc + INSTRUCTION_SIZE_IN_BYTES;
  end

  // Memory model: response lat cycles after the first wait cycle
  assign bus.mem_req_ready = mready;
  assign bus.instr_ready   = rdy;
  assign bus.mem_rsp_valid = rsp_v;
  assign bus.mem_rsp_data  = data_of(paddr);
  assign bus.mem_rsp_err   = rsp_v && (paddr == err_addr);

  always @(posedge clk or negedge res) begin
    if (!res) begin
      rsp_v <= 1'b0;
      cnt   <= 0;
      paddr <= '0;
    end else begin
      if (rsp_v) rsp_v <= 1'b0;
      else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) rsp_v <= 1'b1;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        paddr <= bus.mem_addr;
        sb.push_back('{instr: data_of(bus.mem_addr), addr: bus.mem_addr,
                       fault: (bus.mem_addr == err_addr)});
        if (lat == 0) rsp_v <= 1'b1;
        else cnt <= lat;
      end
    end
  end

  // Scoreboard: a redirect or reset kills everything outstanding
  always @(negedge clk) begin : mon
    fetch_rsp_t e;
    #3;
    if (!res || redirect) sb.delete();
    else if (bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 32'(bus.instr_valid), 0);
      else begin
        e = sb.pop_front();
        chk("sb_instr", bus.instr, e.instr);
        chk("sb_pc", bus.instr_pc, e.addr);
        chk("sb_fault", 32'(bus.instr_fault), 32'(e.fault));
      end
    end
  end

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (bus.instr_valid) return;
    end
    chk({tag, "_timeout"}, 32'(bus.instr_valid), 1);
  endtask

  task automatic wait_acc(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (bus.mem_req_valid && bus.mem_req_ready) return;
    end
    chk({tag, "_timeout"}, 32'(bus.mem_req_valid), 1);
  endtask

  initial begin
    word st_i, st_p;
    int incs;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr", bus.instr, NOP_INSTR);
    chk("rst_pc", bus.instr_pc, 0);
    chk("rst_fault", 32'(bus.instr_fault), 0);
    chk("rst_ivalid", 32'(bus.instr_valid), 0);
    chk("rst_mvalid", 32'(bus.mem_req_valid), 0);
    @(negedge clk); res = 1'b1;

    // zero-wait streaming: one instruction every 3 cycles, one increment each
    wait_valid("t1");
    incs = 0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("t1_valid", 32'(bus.instr_valid), 32'((k % 3) == 0));
      if ((k % 3) == 0) chk("t1_pc", bus.instr_pc, 32'(4 * (k / 3)));
      if (pc_enable && pc_mode == PC_MODE_INCREMENT) incs++;
    end
    chk("t1_incs", incs, 3);

    // slow memory + decode stall
    lat = 2;
    wait_valid("t2a");
    @(negedge clk); rdy = 1'b0;
    wait_valid("t2b");
    chk("t2_pc", bus.instr_pc, 32'h10);
    st_i = bus.instr; st_p = bus.instr_pc;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      chk("t2_instr_stable", bus.instr, st_i);
      chk("t2_pc_stable", bus.instr_pc, st_p);
      chk("t2_ivalid", 32'(bus.instr_valid), 1);
      chk("t2_no_req", 32'(bus.mem_req_valid), 0);
    end
    @(negedge clk); rdy = 1'b1;
    @(negedge clk); #1;
    chk("t2_req_after", 32'(bus.mem_req_valid), 1);

    // redirect in WAIT, response 3 cycles later is drained
    lat = 3;
    wait_acc("t3");
    @(negedge clk); redirect = 1'b1; target = 32'h100; #1;
    chk("t3_en", 32'(pc_enable), 1);
    chk("t3_mode", 32'(pc_mode), 32'(PC_MODE_JUMP));
    @(negedge clk); redirect = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t3_drain_ivalid", 32'(bus.instr_valid), 0);
      chk("t3_drain_en", 32'(pc_enable), 0);
      @(negedge clk);
    end
    #1;
    chk("t3_req", 32'(bus.mem_req_valid), 1);
    chk("t3_addr", bus.mem_addr, 32'h100);

    // redirect coincident with the response
    lat = 0;
    wait_acc("t4");
    @(negedge clk); redirect = 1'b1; target = 32'h200; #1;
    chk("t4_en", 32'(pc_enable), 1);
    chk("t4_mode", 32'(pc_mode), 32'(PC_MODE_JUMP));
    chk("t4_ivalid", 32'(bus.instr_valid), 0);
    @(negedge clk); redirect = 1'b0; #1;
    chk("t4_req", 32'(bus.mem_req_valid), 1);
    chk("t4_addr", bus.mem_addr, 32'h200);
    wait_valid("t4");
    chk("t4_pc", bus.instr_pc, 32'h200);

    // bus error on 0x10
    redirect = 1'b1; target = 32'h10; err_addr = 32'h10;
    @(negedge clk); redirect = 1'b0;
    wait_valid("t5a");
    chk("t5_pc", bus.instr_pc, 32'h10);
    chk("t5_fault", 32'(bus.instr_fault), 1);
    wait_valid("t5b");
    chk("t5_next_pc", bus.instr_pc, 32'h14);
    chk("t5_next_fault", 32'(bus.instr_fault), 0);

    // misaligned PC
    redirect = 1'b1; target = 32'h6; rdy = 1'b0;
    @(negedge clk); redirect = 1'b0; #1;
    chk("t6_no_req", 32'(bus.mem_req_valid), 0);
    chk("t6_en", 32'(pc_enable), 1);
    chk("t6_mode", 32'(pc_mode), 32'(PC_MODE_INCREMENT));
    @(negedge clk); #1;
    chk("t6_instr", bus.instr, NOP_INSTR);
    chk("t6_fault", 32'(bus.instr_fault), 1);
    chk("t6_pc", bus.instr_pc, 32'h6);
    chk("t6_ivalid", 32'(bus.instr_valid), 1);
    chk("t6_no_req2", 32'(bus.mem_req_valid), 0);
    redirect = 1'b1; target = 32'h300;
    @(negedge clk); redirect = 1'b0; rdy = 1'b1;

    // reset while waiting on memory
    lat = 5;
    wait_acc("t7");
    @(negedge clk); res = 1'b0; redirect = 1'b1; #1;
    chk("t7_instr", bus.instr, NOP_INSTR);
    chk("t7_pc", bus.instr_pc, 0);
    chk("t7_fault", 32'(bus.instr_fault), 0);
    chk("t7_mvalid", 32'(bus.mem_req_valid), 0);
    chk("t7_ivalid", 32'(bus.instr_valid), 0);
    chk("t7_en", 32'(pc_enable), 0);
    @(negedge clk); redirect = 1'b0; res = 1'b1; lat = 0; #1;
    chk("t7_start", 32'(bus.mem_req_valid), 0);
    @(negedge clk); #1;
    chk("t7_req", 32'(bus.mem_req_valid), 1);
    chk("t7_addr", bus.mem_addr, 0);
    wait_valid("t7");
    chk("t7_first_pc", bus.instr_pc, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter register.
- Reads the current PC and issues one word read to instruction memory. It captures the returned instruction and presents it to decode over a valid/ready handshake.
- Drives the PC's enable/mode inputs: increment after each successful fetch, jump on a redirect from execute.
- At most one memory request outstanding; pending responses are discarded after a redirect.

Parameters:
- CheckAlign, 1, when 1 a PC with pc[1:0] != 0 is not sent to memory; a fault instruction is produced instead.

Ports:
- clk  input  1  clock, rising edge
- res  input  1  reset, asynchronous, active-low
- pc  input  word  current PC from the PC register
- pc_enable  output  1  PC update strobe, combinational
- pc_mode  output  1  PC_MODE_INCREMENT or PC_MODE_JUMP, combinational
- redirect  input  1  single-cycle jump request from execute (target goes to the PC directly)
- mem_req_valid  output  1  read request valid
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  word  read address
- mem_rsp_valid  input  1  read data valid
- mem_rsp_data  input  word  read data
- mem_rsp_err  input  1  bus error on read
- instr_valid  output  1  instruction available to decode
- instr_ready  input  1  decode accepts instruction
- instr  output  word  fetched instruction
- instr_pc  output  word  address of instr
- instr_fault  output  1  fetch fault (bus error or misaligned)

Behaviour:
- States: S_START, S_REQ, S_WAIT, S_DRAIN, S_HOLD.
- Reset (res low, async):
  - state = S_START; instr = NOP_INSTR (32'h00000013); instr_pc = 0; instr_fault = 0; internal req_pc = 0.
  - All valid/strobe outputs are 0 during reset.
- S_START: one cycle so the PC settles, then go to S_REQ.
- S_REQ:
  - mem_req_valid = !redirect; mem_addr = pc.
  - On handshake (valid and ready), latch req_pc = pc and go to S_WAIT.
  - Misaligned PC with CheckAlign = 1: no request is issued. Load instr = NOP_INSTR, instr_pc = pc, instr_fault = 1. Pulse pc_enable with increment. Go to S_HOLD.
- S_WAIT, on mem_rsp_valid:
  - instr = mem_rsp_data, instr_pc = req_pc, instr_fault = mem_rsp_err.
  - pc_enable = 1 with pc_mode = INCREMENT in the same cycle, so the PC advances on the same edge.
  - Go to S_HOLD.
- S_HOLD:
  - instr_valid = !redirect.
  - On instr_ready, go to S_REQ. The registered instr fields stay stable until then.
- Redirect (highest priority, any state):
  - pc_enable = 1, pc_mode = JUMP that cycle.
  - Any increment that would occur the same cycle is suppressed.
  - Transitions:
    - S_WAIT without rsp_valid -> S_DRAIN.
    - S_WAIT with rsp_valid -> S_REQ; the response is dropped.
    - S_REQ -> S_REQ; the request is withdrawn, which memory must tolerate.
    - S_HOLD -> S_REQ; the held instruction is discarded even if instr_ready is high.
    - S_DRAIN -> S_DRAIN.
  - Redirect during S_START: the PC jump is still forwarded.
- S_DRAIN: wait for mem_rsp_valid, discard the data, go to S_REQ. No PC update.
- Throughput: minimum 3 cycles per instruction with zero-wait memory and instr_ready held high (REQ, WAIT, HOLD).
- A response arriving in S_REQ or S_HOLD is illegal; assert in simulation.
- Reset mid-transaction returns to S_START. An in-flight memory response after reset is outside scope: memory shares the same reset.

Decomposition:
- Shared package definitions.svh holds word, PC_MODE_INCREMENT/PC_MODE_JUMP, INSTRUCTION_SIZE_IN_BYTES, new NOP_INSTR, and the fetch_state_e enum.
- No sub-module; a single FSM plus output registers.

Test Plan:
- Zero-wait memory, instr_ready = 1, pc steps 0x0, 0x4, 0x8 -> instr_valid every 3rd cycle with instr_pc = 0x0, 0x4, 0x8; pc_enable = 1 with INCREMENT once per fetch.
- Memory answers 2 cycles late and decode stalls 4 cycles in S_HOLD -> instr/instr_pc stable for all 4 cycles; no new mem_req_valid until instr_ready.
- Redirect in S_WAIT, response arrives 3 cycles later -> pc_mode = JUMP pulse; S_DRAIN; response discarded, instr_valid stays 0; next request uses the new pc.
- Redirect and mem_rsp_valid in the same cycle -> no INCREMENT, JUMP only, response dropped, back to S_REQ.
- mem_rsp_err = 1 on read of 0x10 -> instr_fault = 1, instr_pc = 0x10, PC still increments.
- pc = 0x6 with CheckAlign = 1 -> no mem_req_valid; instr = 0x00000013, instr_fault = 1, instr_pc = 0x6.
- Assert res low while in S_WAIT -> outputs return to reset values immediately, S_START follows release.
